// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU datapath state encoding and two's-complement helper
// Imported by the sequential divider and reused by the multiplier bench.
package alu_pkg;

  localparam int MAXW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Conditional negation; callers zero-extend into MAXW and size-cast the result back.
  function automatic logic [MAXW-1:0] twos_neg(input logic [MAXW-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/seq_div_sign_if.sv
// rtl/seq_div_sign_if.sv - start/busy/done operand and result bundle for seq_div_sign
// Carries the dz flag only when SEQ_DIV_ZERO_FLAG_EN is defined.
interface seq_div_sign_if #(
  parameter int N = 8,
  parameter int M = 8
);

  logic         start;
  logic [N-1:0] A;
  logic [M-1:0] B;
  logic         sg;
  logic         busy;
  logic         done;
  logic [N-1:0] Q;
  logic [M-1:0] R;
`ifdef SEQ_DIV_ZERO_FLAG_EN
  logic         dz;
`endif

  modport master (
    output start, A, B, sg,
    input  busy, done, Q, R
`ifdef SEQ_DIV_ZERO_FLAG_EN
    , input dz
`endif
  );

  modport slave (
    input  start, A, B, sg,
    output busy, done, Q, R
`ifdef SEQ_DIV_ZERO_FLAG_EN
    , output dz
`endif
  );

endinterface

// File: rtl/seq_div_sign_step.sv
// rtl/seq_div_sign_step.sv - one restoring-division iteration (module div_step)
// Shift in one dividend bit, trial-subtract the divisor magnitude, restore on borrow.
module div_step #(
  parameter int M = 8
) (
  input  logic [M-1:0] rem_in,
  input  logic         bit_in,
  input  logic [M-1:0] divisor,
  output logic [M-1:0] rem_out,
  output logic         q_bit
);

  logic [M:0] shifted;
  logic [M:0] diff;

  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    // A set top bit means shifted >= 2^M, which always exceeds any M-bit divisor.
    q_bit   = shifted[M] | ~diff[M];
    rem_out = q_bit ? diff[M-1:0] : shifted[M-1:0];
  end

endmodule

// File: rtl/seq_div_sign.sv
// rtl/seq_div_sign.sv - radix-2 restoring divider, signed/unsigned, one quotient bit per clock
// SEQ_DIV_ZERO_FLAG_EN adds a dz output reporting divide-by-zero, held with Q/R.
module seq_div_sign
  import alu_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq_div_sign_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  work_q;
  logic [M-1:0]  rem_q;
  logic [M-1:0]  b_mag_q;
  logic [M-1:0]  a_low_q;
  logic          sa_q, sb_q;
  logic          done_q;
  logic [N-1:0]  q_q;
  logic [M-1:0]  r_q;
`ifdef SEQ_DIV_ZERO_FLAG_EN
  logic          dz_q;
`endif

  logic          sa_in, sb_in;
  logic [N-1:0]  a_mag_in;
  logic [M-1:0]  b_mag_in;
  logic [M-1:0]  rem_nxt;
  logic          q_bit;
  logic          div_zero;
  logic [N-1:0]  q_fix;
  logic [M-1:0]  r_fix;

  div_step #(.M(M)) u_step (
    .rem_in  (rem_q),
    .bit_in  (work_q[N-1]),
    .divisor (b_mag_q),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  // Operand magnitudes; the zero-extended negation covers -2^(N-1) without overflow.
  always_comb begin
    sa_in    = bus.sg & bus.A[N-1];
    sb_in    = bus.sg & bus.B[M-1];
    a_mag_in = N'(twos_neg(MAXW'(bus.A), sa_in));
    b_mag_in = M'(twos_neg(MAXW'(bus.B), sb_in));
  end

  always_comb begin
    div_zero = (b_mag_q == '0);
    q_fix    = div_zero ? '1      : N'(twos_neg(MAXW'(work_q), sa_q ^ sb_q));
    r_fix    = div_zero ? a_low_q : M'(twos_neg(MAXW'(rem_q), sa_q));
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (bus.start)     state_n = ST_CALC;
      ST_CALC: if (cnt_q == '0)   state_n = ST_FIX;
      ST_FIX:                     state_n = ST_IDLE;
      default:                    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Quotient bits enter work_q at the LSB as dividend bits leave at the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      work_q  <= '0;
      rem_q   <= '0;
      b_mag_q <= '0;
      a_low_q <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
`ifdef SEQ_DIV_ZERO_FLAG_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            work_q  <= a_mag_in;
            rem_q   <= '0;
            b_mag_q <= b_mag_in;
            a_low_q <= bus.A[M-1:0];
            sa_q    <= sa_in;
            sb_q    <= sb_in;
            cnt_q   <= CW'(N - 1);
          end
        end
        ST_CALC: begin
          work_q <= {work_q[N-2:0], q_bit};
          rem_q  <= rem_nxt;
          cnt_q  <= cnt_q - CW'(1);
        end
        ST_FIX: begin
          q_q    <= q_fix;
          r_q    <= r_fix;
          done_q <= 1'b1;
`ifdef SEQ_DIV_ZERO_FLAG_EN
          dz_q   <= div_zero;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;
  assign bus.Q    = q_q;
  assign bus.R    = r_q;
`ifdef SEQ_DIV_ZERO_FLAG_EN
  assign bus.dz   = dz_q;
`endif

endmodule

// File: tb/tb_seq_div_sign.sv
// tb/tb_seq_div_sign.sv - scoreboard bench for seq_div_sign with N=M=8
// Checks dz as well when SEQ_DIV_ZERO_FLAG_EN is defined.
module tb_seq_div_sign;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    string      tag;
  } exp_t;

  exp_t sb[$];

  seq_div_sign_if #(.N(8), .M(8)) bus ();

  seq_div_sign #(.N(8), .M(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got done=1 want no pending result");
      end else begin
        e = sb.pop_front();
        if (bus.Q !== e.q) begin
          errors++;
          $display("FAIL %s_Q got %h want %h", e.tag, bus.Q, e.q);
        end
        checks++;
        if (bus.R !== e.r) begin
          errors++;
          $display("FAIL %s_R got %h want %h", e.tag, bus.R, e.r);
        end
`ifdef SEQ_DIV_ZERO_FLAG_EN
        checks++;
        if (bus.dz !== e.dz) begin
          errors++;
          $display("FAIL %s_dz got %b want %b", e.tag, bus.dz, e.dz);
        end
`endif
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  // Entered at the negedge following the accepting edge (j = j0); returns at the done negedge.
  task automatic wait_done(input string tag, input int j0);
    int j;
    int busy_cycles;
    j = j0;
    busy_cycles = 0;
    while (!bus.done && j < 40) begin
      if (bus.busy) busy_cycles++;
      @(negedge clk);
      j++;
    end
    if (!bus.done) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_latency"}, j, 9);
      check({tag, "_busy_cycles"}, busy_cycles, 9 - j0);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [7:0] eq, input logic [7:0] er, input string tag);
    exp_t e;
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.sg = s;
    e.q = eq;
    e.r = er;
    e.dz = (b == 8'd0);
    e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(tag, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] a, b;
    logic       s;
    int         ai, bi, qi, ri;
    int         seen;
    exp_t       e;

    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.sg = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_Q", bus.Q, 0);
    check("rst_R", bus.R, 0);
`ifdef SEQ_DIV_ZERO_FLAG_EN
    check("rst_dz", bus.dz, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Consecutive calls issue start in the done cycle of the previous operation.
    run_op(8'd200, 8'd7,   1'b0, 8'd28,  8'd4,   "u200_7");
    run_op(8'h9C,  8'd7,   1'b1, 8'hF2,  8'hFE,  "sm100_7");
    run_op(8'd100, 8'hF9,  1'b1, 8'hF2,  8'd2,   "s100_m7");
    run_op(8'h9C,  8'hF9,  1'b1, 8'd14,  8'hFE,  "sm100_m7");
    run_op(8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  "ovf");
    run_op(8'h5A,  8'h00,  1'b0, 8'hFF,  8'h5A,  "dz_u");
    run_op(8'h5A,  8'h00,  1'b1, 8'hFF,  8'h5A,  "dz_s");
    run_op(8'd255, 8'd16,  1'b0, 8'd15,  8'd15,  "u255_16");
    run_op(8'h7F,  8'h80,  1'b1, 8'h00,  8'h7F,  "s127_m128");
    run_op(8'h80,  8'h02,  1'b1, 8'hC0,  8'h00,  "sm128_2");
    run_op(8'hFF,  8'h80,  1'b1, 8'h00,  8'hFF,  "sm1_m128");
    run_op(8'd255, 8'd255, 1'b0, 8'd1,   8'd0,   "u255_255");
    run_op(8'd5,   8'd200, 1'b0, 8'd0,   8'd5,   "u5_200");
    run_op(8'd255, 8'd1,   1'b0, 8'd255, 8'd0,   "u255_1");

    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (b == 8'd0) b = 8'd1;
      s = 1'($urandom_range(0, 1));
      ai = s ? int'($signed(a)) : int'(a);
      bi = s ? int'($signed(b)) : int'(b);
      qi = ai / bi;
      ri = ai % bi;
      run_op(a, b, s, qi[7:0], ri[7:0], $sformatf("rnd%0d", i));
    end

    // A second start while busy must not disturb the running operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = 8'd200;
    bus.B = 8'd7;
    bus.sg = 1'b0;
    e.q = 8'd28;
    e.r = 8'd4;
    e.dz = 1'b0;
    e.tag = "busy_ign";
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.A = 8'h11;
    bus.B = 8'd3;
    bus.sg = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = 8'h00;
    wait_done("busy_ign", 4);

    // Reset four cycles into an operation: outputs clear at once and no done follows.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = 8'h9C;
    bus.B = 8'd7;
    bus.sg = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_Q", bus.Q, 0);
    check("midrst_R", bus.R, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    check("midrst_no_done", seen, 0);

    run_op(8'd100, 8'd9, 1'b0, 8'd11, 8'd1, "after_rst");
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
